universal_shift_register: RTL and testbench
===========================================

Name: universal_shift_register

Overview:
- Parametrised successor to the single-bit edge-triggered D flip-flop: a WIDTH-bit register with clock enable and eight operating modes (hold, load, shift, rotate, count).
- Also executes multi-cycle shift/rotate commands by SHAMT positions, one position per enabled clock, with a BUSY/DONE handshake.
- Used as the general-purpose storage/shift element in datapath labs.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- RESET_VALUE, 0, value loaded into Q on reset.
- CNT_W, $clog2(WIDTH)+1, width of SHAMT and the internal step counter.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous, active-low reset.
- EN  input  1  clock enable; low freezes all state, including the step counter.
- MODE  input  3  operation select; sampled only when IDLE.
- D  input  WIDTH  parallel load data.
- SIN  input  1  serial input; sampled on every shift step.
- START  input  1  command strobe; sampled only when IDLE and EN=1.
- SHAMT  input  CNT_W  step count for a START command.
- Q  output  WIDTH  register contents.
- SOUT  output  1  registered bit most recently shifted or rotated out.
- BUSY  output  1  high while a multi-cycle command runs.
- DONE  output  1  one-cycle pulse when a command completes.

Behaviour:
- Reset state (asynchronous, RST_N=0): Q=RESET_VALUE, SOUT=0, BUSY=0, DONE=0, state=IDLE, counter=0. Reset asserted mid-command aborts the command; no DONE is issued.
- Mode encodings:
  - 000 hold.
  - 001 load D.
  - 010 shift left: SIN enters bit 0, bit WIDTH-1 goes to SOUT.
  - 011 shift right: SIN enters MSB, bit 0 goes to SOUT.
  - 100 rotate left.
  - 101 rotate right. For rotates, SOUT is the bit that wrapped.
  - 110 increment, modulo 2^WIDTH.
  - 111 decrement, modulo 2^WIDTH.
- IDLE with EN=1 and START=0: the MODE operation is applied once per clock (free-running operation). DONE=0.
- IDLE with EN=1, START=1 and MODE in 010..101:
  - SHAMT=0: Q unchanged, stay IDLE, DONE=1 on the next cycle.
  - SHAMT>0: latch MODE, perform the first step in this same cycle, counter=SHAMT-1. Go to RUN if the counter is nonzero; otherwise DONE=1 next cycle.
- IDLE with EN=1, START=1 and any other MODE: the operation is applied once; DONE=1 next cycle; BUSY stays 0.
- RUN state:
  - BUSY=1.
  - Each EN=1 clock applies the latched op and decrements the counter.
  - On the step where the counter reaches 0: return to IDLE, BUSY=0 and DONE=1 in the following cycle.
  - MODE, D and START are ignored.
  - EN=0 stalls: Q, counter and BUSY all hold.
- Total latency: a START with SHAMT=N>0 yields exactly N steps. DONE is visible N cycles after the START edge when EN stays high.
- SHAMT>=WIDTH is legal. Shift by WIDTH fills Q entirely with SIN history. Rotate by WIDTH returns the original value.
- DONE is high for exactly one cycle. It is not held off by EN=0.
- SOUT changes only on shift/rotate steps; load, count and hold leave it unchanged.

Optional Feature:
- Macro: USR_PARITY_EN.
- Defined: adds output PARITY (1 bit), a registered even-parity of the next value of Q, updated on the same edge as Q. Its reset value is the parity of RESET_VALUE.
- Undefined: the port is absent; there is no other behavioural change.

Decomposition:
- Package usr_pkg holds:
  - mode localparams: MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_INC, MODE_DEC;
  - state encodings S_IDLE and S_RUN.
- One sub-module, usr_step_unit: combinational next-Q/next-SOUT function of (Q, mode, SIN, D). It is instantiated once and shared by the free-running and RUN paths.
- The top level holds the FSM, counter and registers.

Test Plan (WIDTH=8):
- Reset: RST_N low asynchronously mid-RUN -> Q=0x00, BUSY=0, DONE=0, SOUT=0 immediately, with no DONE after release.
- Free-running modes, EN=1, no START:
  - load 0xA5, then MODE=100 for 1 clock -> Q=0x4B, SOUT=1;
  - MODE=111 from 0x00 -> Q=0xFF.
- Multi-cycle shift: Q=0x81, START, MODE=010, SHAMT=3, SIN=1 -> BUSY high for 2 cycles, final Q=0x0F, SOUT=0, DONE pulse 3 cycles after the START edge.
- Stall: same command with EN low for 4 cycles mid-RUN -> Q and BUSY frozen, same final Q, DONE delayed by 4 cycles. MODE/D toggled during RUN have no effect.
- Boundary:
  - SHAMT=0 -> Q unchanged, DONE next cycle, BUSY never high;
  - ROR with SHAMT=8 on 0x3C -> Q=0x3C after 8 steps;
  - INC from 0xFF -> 0x00.
- With USR_PARITY_EN: load 0x07 -> PARITY=1; INC to 0x08 -> PARITY=1; load 0x03 -> PARITY=0.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation codes,
// controller state encoding and the helper that classifies multi-step ops.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } usr_state_e;

  // Shifts and rotates are the only operations a START can repeat SHAMT times.
  function automatic logic is_multi_step(input logic [2:0] mode);
    return (mode >= MODE_SHL) && (mode <= MODE_ROR);
  endfunction

endpackage

// File: rtl/usr_step_unit.sv
// One step of the register datapath: next Q and next serial-out bit for a
// given operation. Purely combinational; the top level decides when a step
// is committed and which operation code (live MODE or latched op) drives it.
module usr_step_unit
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_nxt,
  output logic             sout_nxt,
  output logic             sout_upd
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Select the next register value; sout_upd flags ops that move a bit out.
  always_comb begin
    q_nxt    = q;
    sout_nxt = 1'b0;
    sout_upd = 1'b0;
    case (mode)
      MODE_HOLD: q_nxt = q;
      MODE_LOAD: q_nxt = d;
      MODE_SHL: begin
        q_nxt    = {q[WIDTH-2:0], sin};
        sout_nxt = q[WIDTH-1];
        sout_upd = 1'b1;
      end
      MODE_SHR: begin
        q_nxt    = {sin, q[WIDTH-1:1]};
        sout_nxt = q[0];
        sout_upd = 1'b1;
      end
      MODE_ROL: begin
        q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
        sout_nxt = q[WIDTH-1];
        sout_upd = 1'b1;
      end
      MODE_ROR: begin
        q_nxt    = {q[0], q[WIDTH-1:1]};
        sout_nxt = q[0];
        sout_upd = 1'b1;
      end
      MODE_INC: q_nxt = q + ONE;
      MODE_DEC: q_nxt = q - ONE;
      default:  q_nxt = q;
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: WIDTH-bit register with clock enable, eight
// operations (hold/load/shift/rotate/count) and a START/SHAMT command that
// repeats a shift or rotate over several enabled clocks with BUSY/DONE.
// Optional build macro USR_PARITY_EN adds a registered even-parity output
// PARITY tracking Q; without it the port does not exist.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIN,
  input  logic             START,
  input  logic [CNT_W-1:0] SHAMT,
  output logic [WIDTH-1:0] Q,
  output logic             SOUT,
  output logic             BUSY,
  output logic             DONE
`ifdef USR_PARITY_EN
  ,
  output logic             PARITY
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  usr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;

  logic [2:0]       step_mode;
  logic [WIDTH-1:0] step_q;
  logic             step_sout;
  logic             step_sout_upd;
  logic [CNT_W-1:0] shamt_m1;

  // While a command runs the latched op drives the datapath, so MODE is ignored.
  assign step_mode = (state_q == S_RUN) ? op_q : MODE;
  assign shamt_m1  = SHAMT - CNT_ONE;

  usr_step_unit #(
    .WIDTH (WIDTH)
  ) u_step (
    .q        (q_q),
    .mode     (step_mode),
    .sin      (SIN),
    .d        (D),
    .q_nxt    (step_q),
    .sout_nxt (step_sout),
    .sout_upd (step_sout_upd)
  );

  // Next-state logic: free-running ops, command launch and RUN stepping.
  // DONE defaults low every clock, so a pulse lasts one cycle even with EN=0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    q_d     = q_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    if (EN) begin
      case (state_q)
        S_IDLE: begin
          if (START && is_multi_step(MODE)) begin
            if (SHAMT == '0) begin
              done_d = 1'b1;
            end else begin
              q_d  = step_q;
              if (step_sout_upd) sout_d = step_sout;
              op_d  = MODE;
              cnt_d = shamt_m1;
              if (shamt_m1 != '0) begin
                state_d = S_RUN;
              end else begin
                done_d = 1'b1;
              end
            end
          end else begin
            // Plain operation; a START on a single-step op just completes at once.
            q_d = step_q;
            if (step_sout_upd) sout_d = step_sout;
            done_d = START;
          end
        end
        S_RUN: begin
          q_d = step_q;
          if (step_sout_upd) sout_d = step_sout;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Register bank; reset aborts any command in flight without a DONE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= MODE_HOLD;
      q_q     <= RESET_VALUE;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  assign Q    = q_q;
  assign SOUT = sout_q;
  assign BUSY = (state_q == S_RUN);
  assign DONE = done_q;

`ifdef USR_PARITY_EN
  logic parity_q, parity_d;

  assign parity_d = ^q_d;

  // Parity follows the value Q takes on the same edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      parity_q <= ^RESET_VALUE;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign PARITY = parity_q;
`endif

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register (WIDTH=8, RESET_VALUE=0).
module tb_universal_shift_register;

  import usr_pkg::*;

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic [2:0] MODE;
  logic [7:0] D;
  logic       SIN;
  logic       START;
  logic [3:0] SHAMT;
  logic [7:0] Q;
  logic       SOUT;
  logic       BUSY;
  logic       DONE;
`ifdef USR_PARITY_EN
  logic       PARITY;
`endif

  int n_checks = 0;
  int n_errors = 0;

  universal_shift_register #(
    .WIDTH       (8),
    .RESET_VALUE (8'h00)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .EN    (EN),
    .MODE  (MODE),
    .D     (D),
    .SIN   (SIN),
    .START (START),
    .SHAMT (SHAMT),
    .Q     (Q),
    .SOUT  (SOUT),
    .BUSY  (BUSY),
    .DONE  (DONE)
`ifdef USR_PARITY_EN
    ,
    .PARITY(PARITY)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N = 1'b0; EN = 1'b0; MODE = MODE_HOLD; D = 8'h00;
    SIN = 1'b0; START = 1'b0; SHAMT = 4'd0;
    #12;
    check("rst_q", Q, 8'h00);
    check("rst_sout", SOUT, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_done", DONE, 1'b0);
`ifdef USR_PARITY_EN
    check("rst_parity", PARITY, 1'b0);
`endif
    RST_N = 1'b1;

    // Free-running: load then rotate left
    EN = 1'b1; MODE = MODE_LOAD; D = 8'hA5;
    tick();
    check("load_q", Q, 8'hA5);
    check("load_sout", SOUT, 1'b0);
    check("load_done", DONE, 1'b0);
    MODE = MODE_ROL;
    tick();
    check("rol_q", Q, 8'h4B);
    check("rol_sout", SOUT, 1'b1);
    MODE = MODE_HOLD;
    tick();
    check("hold_q", Q, 8'h4B);
    check("hold_sout", SOUT, 1'b1);
    MODE = MODE_SHL; SIN = 1'b0;
    tick();
    check("shl1_q", Q, 8'h96);
    check("shl1_sout", SOUT, 1'b0);
    MODE = MODE_SHR; SIN = 1'b1;
    tick();
    check("shr1_q", Q, 8'hCB);
    check("shr1_sout", SOUT, 1'b0);
    MODE = MODE_LOAD; D = 8'h00;
    tick();
    MODE = MODE_DEC;
    tick();
    check("dec_q", Q, 8'hFF);
    check("dec_sout", SOUT, 1'b0);
    MODE = MODE_INC;
    tick();
    check("inc_wrap_q", Q, 8'h00);

    // Multi-cycle shift left by 3 with SIN=1
    MODE = MODE_LOAD; D = 8'h81;
    tick();
    START = 1'b1; MODE = MODE_SHL; SHAMT = 4'd3; SIN = 1'b1;
    tick();
    START = 1'b0; MODE = MODE_HOLD;
    check("mc_s1_q", Q, 8'h03);
    check("mc_s1_busy", BUSY, 1'b1);
    check("mc_s1_done", DONE, 1'b0);
    tick();
    check("mc_s2_q", Q, 8'h07);
    check("mc_s2_busy", BUSY, 1'b1);
    check("mc_s2_done", DONE, 1'b0);
    tick();
    check("mc_s3_q", Q, 8'h0F);
    check("mc_s3_sout", SOUT, 1'b0);
    check("mc_s3_busy", BUSY, 1'b0);
    check("mc_s3_done", DONE, 1'b1);
    tick();
    check("mc_done_pulse", DONE, 1'b0);
    check("mc_hold_q", Q, 8'h0F);

    // Same command with a 4-cycle stall and MODE/D/START noise during RUN
    MODE = MODE_LOAD; D = 8'h81;
    tick();
    START = 1'b1; MODE = MODE_SHL; SHAMT = 4'd3; SIN = 1'b1;
    tick();
    check("st_s1_q", Q, 8'h03);
    MODE = MODE_LOAD; D = 8'h55; EN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("st_frozen_q", Q, 8'h03);
      check("st_frozen_busy", BUSY, 1'b1);
      check("st_frozen_done", DONE, 1'b0);
    end
    EN = 1'b1; MODE = MODE_INC; D = 8'hAA;
    tick();
    check("st_s2_q", Q, 8'h07);
    check("st_s2_busy", BUSY, 1'b1);
    START = 1'b0; MODE = MODE_HOLD;
    tick();
    check("st_s3_q", Q, 8'h0F);
    check("st_s3_sout", SOUT, 1'b0);
    check("st_s3_busy", BUSY, 1'b0);
    check("st_s3_done", DONE, 1'b1);

    // SHAMT=1 completes at once; DONE drops even with EN low
    START = 1'b1; MODE = MODE_SHL; SHAMT = 4'd1; SIN = 1'b0;
    tick();
    START = 1'b0; MODE = MODE_HOLD;
    check("one_q", Q, 8'h1E);
    check("one_busy", BUSY, 1'b0);
    check("one_done", DONE, 1'b1);
    EN = 1'b0;
    tick();
    check("one_done_en0", DONE, 1'b0);
    check("one_q_en0", Q, 8'h1E);
    EN = 1'b1;

    // SHAMT=0: no change, DONE next cycle, never busy
    START = 1'b1; MODE = MODE_SHR; SHAMT = 4'd0; SIN = 1'b1;
    tick();
    START = 1'b0; MODE = MODE_HOLD;
    check("z_q", Q, 8'h1E);
    check("z_busy", BUSY, 1'b0);
    check("z_done", DONE, 1'b1);
    tick();
    check("z_done_pulse", DONE, 1'b0);
    check("z_busy2", BUSY, 1'b0);

    // Rotate right by WIDTH restores the value
    MODE = MODE_LOAD; D = 8'h3C;
    tick();
    START = 1'b1; MODE = MODE_ROR; SHAMT = 4'd8;
    tick();
    START = 1'b0; MODE = MODE_HOLD;
    check("ror8_s1_q", Q, 8'h1E);
    check("ror8_s1_busy", BUSY, 1'b1);
    repeat (6) tick();
    check("ror8_s7_busy", BUSY, 1'b1);
    check("ror8_s7_done", DONE, 1'b0);
    tick();
    check("ror8_q", Q, 8'h3C);
    check("ror8_sout", SOUT, 1'b0);
    check("ror8_done", DONE, 1'b1);
    check("ror8_busy", BUSY, 1'b0);

    // START with a single-step op: applied once, DONE, no BUSY
    START = 1'b1; MODE = MODE_LOAD; D = 8'h5A;
    tick();
    START = 1'b0; MODE = MODE_HOLD;
    check("sld_q", Q, 8'h5A);
    check("sld_done", DONE, 1'b1);
    check("sld_busy", BUSY, 1'b0);

    // Asynchronous reset mid-RUN
    MODE = MODE_LOAD; D = 8'h81;
    tick();
    START = 1'b1; MODE = MODE_SHL; SHAMT = 4'd5; SIN = 1'b0;
    tick();
    START = 1'b0; MODE = MODE_HOLD;
    check("ar_pre_busy", BUSY, 1'b1);
    check("ar_pre_sout", SOUT, 1'b1);
    #2 RST_N = 1'b0;
    #1;
    check("ar_q", Q, 8'h00);
    check("ar_busy", BUSY, 1'b0);
    check("ar_done", DONE, 1'b0);
    check("ar_sout", SOUT, 1'b0);
    #1 RST_N = 1'b1;
    begin
      logic saw_done;
      saw_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
        tick();
        saw_done = saw_done | DONE;
      end
      check("ar_no_done", saw_done, 1'b0);
      check("ar_post_busy", BUSY, 1'b0);
    end

`ifdef USR_PARITY_EN
    MODE = MODE_LOAD; D = 8'h07;
    tick();
    check("par_07", PARITY, 1'b1);
    MODE = MODE_INC;
    tick();
    check("par_08_q", Q, 8'h08);
    check("par_08", PARITY, 1'b1);
    MODE = MODE_LOAD; D = 8'h03;
    tick();
    check("par_03", PARITY, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
